// File: rtl/tag_free_list.sv
// tag_free_list: 64-entry circular free list of 6-bit physical tags.
// Tag 0 means "no tag" and is never stored or handed out; legal tags are 1..63.
// Optional feature: define TAG_FREE_LIST_BYPASS_EN so that a tag freed while
// the list is empty goes straight to a waiting allocation in the same cycle.
//
// Handshake: alloc_valid is a same-cycle grant. When alloc_req is high and
// alloc_valid is high, alloc_tag is consumed at the next rising edge. When
// alloc_valid is low the request has no effect and dispatch retries later.
// free_valid has no back-pressure: a zero tag is ignored, and a nonzero tag
// arriving while 63 tags are held is dropped and latches overflow_err.
module tag_free_list (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_valid,
  output logic [5:0] alloc_tag,
  input  logic       free_valid,
  input  logic [5:0] free_tag,
  input  logic       flush,
  output logic [5:0] free_count,
  output logic       empty,
  output logic       overflow_err
);

  localparam logic [5:0] FULL_COUNT = 6'd63;

  logic [5:0] queue [64];
  logic [5:0] head;
  logic [5:0] tail;
  logic [5:0] count_q;
  logic       overflow_q;

  logic       free_nonzero;
  logic       free_legal;
  logic       free_drop;
  logic       pop;
  logic       push;
  logic       bypass;

  assign empty        = (count_q == 6'd0);
  assign free_count   = count_q;
  assign overflow_err = overflow_q;

  // A free is accepted only while there is room for it.
  assign free_nonzero = free_valid && (free_tag != 6'd0);
  assign free_legal   = free_nonzero && (count_q != FULL_COUNT);
  assign free_drop    = free_nonzero && (count_q == FULL_COUNT);

`ifdef TAG_FREE_LIST_BYPASS_EN
  // Empty list, a waiting request and an incoming tag: forward the tag.
  assign bypass = empty && alloc_req && free_legal && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  // Reset and flush both suppress the grant, since neither consumes a tag.
  assign pop  = alloc_req && !empty && !flush && !rst;
  // A forwarded tag never touches the queue.
  assign push = free_legal && !bypass && !flush && !rst;

  // Grant output: forwarded tag when bypassing, otherwise the queue head.
  always_comb begin
    alloc_valid = pop || bypass;
    alloc_tag   = bypass ? free_tag : queue[head];
  end

  // Queue contents, pointers and count; reset and flush restore the 1..63 fill.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < 63; i++) begin
        queue[i] <= 6'(i + 1);
      end
      queue[63] <= 6'd0;
      head      <= 6'd0;
      tail      <= 6'd63;
      count_q   <= FULL_COUNT;
    end else begin
      if (push) begin
        queue[tail] <= free_tag;
        tail        <= tail + 6'd1;
      end
      if (pop) begin
        head <= head + 6'd1;
      end
      case ({pop, push})
        2'b10:   count_q <= count_q - 6'd1;
        2'b01:   count_q <= count_q + 6'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag: cleared only by reset, kept across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (!flush && free_drop) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list: directed bench for tag_free_list with a grant scoreboard.
// Expected tags are queued when the tag-producing stimulus is driven and
// popped whenever the DUT grants.
module tb_tag_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic       free_valid;
  logic [5:0] free_tag;
  logic       flush;
  logic [5:0] free_count;
  logic       empty;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  // Clock and reset-time defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  tag_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .flush        (flush),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = 6'd0;
    flush      = 1'b0;
  endtask

  task automatic check(input string name, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Scoreboard: a grant must be expected and carry the oldest expected tag.
  task automatic grant_step(input string name);
    logic [5:0] e;
    check({name, "_valid"}, {5'b0, alloc_valid}, 6'd1);
    if (alloc_valid) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        failures++;
        $error("FAIL %s_sb observed=%0d expected=no_grant", name, alloc_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({name, "_tag"}, alloc_tag, e);
      end
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      alloc_req = 1'b1;
      #1;
      grant_step(name);
      tick();
    end
    idle();
  endtask

  task automatic free_one(input logic [5:0] t);
    idle();
    free_valid = 1'b1;
    free_tag   = t;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    logic [5:0] t;

    // Reset held with active inputs: no grant
    idle();
    rst        = 1'b1;
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd5;
    tick();
    check("rst_alloc_valid", {5'b0, alloc_valid}, 6'd0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    check("rst_count", free_count, 6'd63);
    check("rst_empty", {5'b0, empty}, 6'd0);
    check("rst_overflow", {5'b0, overflow_err}, 6'd0);
    check("rst_tag", alloc_tag, 6'd1);

    // Free into a full list sets sticky overflow; reset clears it
    free_one(6'd7);
    #1;
    check("ovf_set", {5'b0, overflow_err}, 6'd1);
    check("ovf_count", free_count, 6'd63);
    tick();
    check("ovf_sticky", {5'b0, overflow_err}, 6'd1);
    do_reset();
    check("ovf_cleared", {5'b0, overflow_err}, 6'd0);

    // Allocate all 63 tags in order
    for (int i = 1; i <= 63; i++) exp_q.push_back(6'(i));
    drain("full_drain", 63);
    alloc_req = 1'b1;
    #1;
    check("empty_flag", {5'b0, empty}, 6'd1);
    check("empty_no_grant", {5'b0, alloc_valid}, 6'd0);
    check("empty_count", free_count, 6'd0);
    tick();
    idle();
    check("empty_ignored_count", free_count, 6'd0);

    // Frees 5, 9, 2 then allocate them back across the pointer wrap
    free_one(6'd5); exp_q.push_back(6'd5);
    free_one(6'd9); exp_q.push_back(6'd9);
    free_one(6'd2); exp_q.push_back(6'd2);
    #1;
    check("wrap_count", free_count, 6'd3);
    drain("wrap", 3);
    check("wrap_empty", {5'b0, empty}, 6'd1);

    // Allocate and free in the same cycle while empty
    idle();
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd30;
    #1;
`ifdef TAG_FREE_LIST_BYPASS_EN
    exp_q.push_back(6'd30);
    grant_step("bypass");
    tick();
    idle();
    check("bypass_count", free_count, 6'd0);
`else
    check("nobypass_valid", {5'b0, alloc_valid}, 6'd0);
    tick();
    idle();
    check("nobypass_count", free_count, 6'd1);
    exp_q.push_back(6'd30);
    drain("nobypass_next", 1);
`endif
    check("post_bypass_empty", {5'b0, empty}, 6'd1);

    // Simultaneous grant and free with a single tag held
    free_one(6'd40);
    exp_q.push_back(6'd40);
    idle();
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd12;
    #1;
    grant_step("one_left");
    tick();
    idle();
    #1;
    check("one_left_count", free_count, 6'd1);
    check("one_left_next_tag", alloc_tag, 6'd12);
    exp_q.push_back(6'd12);
    drain("one_left_drain", 1);

    // Zero tag is ignored
    free_one(6'd0);
    #1;
    check("zero_tag_count", free_count, 6'd0);
    check("zero_tag_empty", {5'b0, empty}, 6'd1);

    // Random refill and drain
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      t = 6'($urandom_range(1, 63));
      free_one(t);
      exp_q.push_back(t);
    end
    #1;
    check("rand_count", free_count, 6'(n));
    drain("rand", n);
    check("rand_empty", {5'b0, empty}, 6'd1);

    // Flush after 20 allocations, with overflow set beforehand
    do_reset();
    free_one(6'd7);
    for (int i = 1; i <= 20; i++) exp_q.push_back(6'(i));
    drain("pre_flush", 20);
    #1;
    check("pre_flush_count", free_count, 6'd43);
    check("pre_flush_tag", alloc_tag, 6'd21);
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd3;
    flush      = 1'b1;
    #1;
    check("flush_no_grant", {5'b0, alloc_valid}, 6'd0);
    tick();
    idle();
    #1;
    check("flush_count", free_count, 6'd63);
    check("flush_tag", alloc_tag, 6'd1);
    check("flush_keeps_ovf", {5'b0, overflow_err}, 6'd1);
    check("flush_empty", {5'b0, empty}, 6'd0);

    // Scoreboard must be fully consumed
    check("sb_leftover", 6'(exp_q.size()), 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
